timer_ctrl: RTL and testbench

//  Multi-channel interval-timer controller sharing one free-running prescaler across NUM_CH channels.

---
 rtl/timer_ctrl.sv | 136 +++++++++++++
 tb/tb_timer_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - multi-channel interval timer sharing one free-running prescaler
// Optional sticky overrun flags are built only when TIMER_CTRL_OVERRUN_EN is defined.
module timer_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 50
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
  input  logic [CNT_W-1:0]          cmd_period,
  input  logic                      cmd_periodic,
  output logic [NUM_CH-1:0]         active,
  output logic [NUM_CH-1:0]         irq,
  input  logic [NUM_CH-1:0]         irq_ack,
  output logic [NUM_CH-1:0]         overrun
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;

  typedef enum logic {IDLE, RUN} state_t;

  logic [PS_W-1:0]   presc_q;
  logic              base_tick;
  logic              accept;
  state_t            state_q  [NUM_CH];
  state_t            state_d  [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] irq_q, irq_d;

  assign base_tick = (presc_q == '0);
  assign accept    = cmd_valid & cmd_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q   <= PS_W'(PRESCALE - 1);
      cmd_ready <= 1'b0;
      mode_q    <= '0;
      irq_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= IDLE;
        count_q[i]  <= '0;
        period_q[i] <= '0;
      end
    end else begin
      presc_q   <= base_tick ? PS_W'(PRESCALE - 1) : presc_q - PS_W'(1);
      cmd_ready <= 1'b1;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

  // Expiry is resolved first so a same-cycle command overrides count/state but never the irq set.
  always_comb begin
    mode_d = mode_q;
    irq_d  = irq_q & ~irq_ack;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      period_d[i] = period_q[i];
      if (state_q[i] == RUN && base_tick) begin
        if (count_q[i] == CNT_W'(1)) begin
          irq_d[i] = 1'b1;
          if (mode_q[i]) begin
            count_d[i] = period_q[i];
          end else begin
            state_d[i] = IDLE;
            count_d[i] = '0;
          end
        end else begin
          count_d[i] = count_q[i] - CNT_W'(1);
        end
      end
      if (accept && cmd_ch == CH_W'(i)) begin
        if (cmd_op == OP_START && cmd_period != '0) begin
          state_d[i]  = RUN;
          count_d[i]  = cmd_period;
          period_d[i] = cmd_period;
          mode_d[i]   = cmd_periodic;
        end else if (cmd_op == OP_STOP) begin
          state_d[i] = IDLE;
          count_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = (state_q[i] == RUN);
    end
  end

  assign irq = irq_q;

`ifdef TIMER_CTRL_OVERRUN_EN
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] ovr_q;

  always_comb begin
    expire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      expire[i] = (state_q[i] == RUN) && base_tick && (count_q[i] == CNT_W'(1));
    end
  end

  // An unacked irq that fires again means software missed an event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= (ovr_q | (expire & irq_q & ~irq_ack)) & ~(irq_ack & ~expire);
    end
  end

  assign overrun = ovr_q;
`else
  assign overrun = '0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed scoreboard bench for timer_ctrl
// Expected irq rise cycles are queued at command time and matched against observed rises.
`timescale 1ns/1ps
module tb_timer_ctrl;
  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 16;
  localparam int PRESCALE = 4;
`ifdef TIMER_CTRL_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_ch;
  logic [CNT_W-1:0]  cmd_period;
  logic              cmd_periodic;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] irq;
  logic [NUM_CH-1:0] irq_ack;
  logic [NUM_CH-1:0] overrun;

  timer_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(PRESCALE)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_period(cmd_period), .cmd_periodic(cmd_periodic),
    .active(active), .irq(irq), .irq_ack(irq_ack), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int ch;
  } exp_t;

  exp_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  int                cycle  = 0;
  int                tb_presc;
  logic [NUM_CH-1:0] irq_prev = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) tb_presc <= PRESCALE - 1;
    else        tb_presc <= (tb_presc == 0) ? PRESCALE - 1 : tb_presc - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    cycle++;
    for (int c = 0; c < NUM_CH; c++) begin
      logic due;
      logic rose;
      due = 1'b0;
      for (int k = 0; k < sb.size(); k++) begin
        if (sb[k].cyc == cycle && sb[k].ch == c) begin
          due = 1'b1;
          sb.delete(k);
          break;
        end
      end
      rose = irq[c] & ~irq_prev[c];
      if (due || rose) check($sformatf("irq_rise_ch%0d_cyc%0d", c, cycle), {31'b0, rose}, {31'b0, due});
    end
    irq_prev     = irq;
    cmd_valid    = 1'b0;
    cmd_op       = 2'd0;
    irq_ack      = '0;
  endtask

  task automatic run_to(input int tgt);
    while (cycle < tgt) step();
  endtask

  task automatic cmd(input logic [1:0] op, input int ch, input int period, input logic per);
    check("cmd_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_ch       = 2'(ch);
    cmd_period   = CNT_W'(period);
    cmd_periodic = per;
  endtask

  function automatic int first_tick(input int t, input int p);
    return t + ((p == 0) ? PRESCALE : p);
  endfunction

  initial begin
    int t;
    int r;
    int a;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_ch = 2'd0; cmd_period = '0; cmd_periodic = 1'b0;
    irq_ack = '0;
    repeat (3) step();
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_active", {28'b0, active}, 32'd0);
    check("rst_irq", {28'b0, irq}, 32'd0);
    check("rst_overrun", {28'b0, overrun}, 32'd0);
    reset = 1'b1;
    step();
    check("ready_after_release", {31'b0, cmd_ready}, 32'd1);

    // periodic ch0, period 3, accepted on a base_tick cycle
    for (int k = 0; k < 2 * PRESCALE; k++) begin
      if (tb_presc == 0) break;
      step();
    end
    t = cycle;
    cmd(2'd1, 0, 3, 1'b1);
    sb.push_back('{t + 13, 0});
    sb.push_back('{t + 25, 0});
    step();
    check("t1_active0", {31'b0, active[0]}, 32'd1);
    run_to(t + 14);
    irq_ack = 4'b0001;
    step();
    check("t1_ack_clears", {31'b0, irq[0]}, 32'd0);
    // ack collides with the next re-expiry: set must win
    run_to(t + 36);
    irq_ack = 4'b0001;
    step();
    check("t3_set_wins", {31'b0, irq[0]}, 32'd1);

    // one-shot ch1, period 1
    t = cycle;
    r = first_tick(t, tb_presc) + 1;
    cmd(2'd1, 1, 1, 1'b0);
    sb.push_back('{r, 1});
    step();
    check("t2_active1_run", {31'b0, active[1]}, 32'd1);
    run_to(r);
    check("t2_active1_idle", {31'b0, active[1]}, 32'd0);
    check("t2_irq1_set", {31'b0, irq[1]}, 32'd1);
    run_to(r + 3);
    check("t2_irq1_hold", {31'b0, irq[1]}, 32'd1);
    irq_ack = 4'b0010;
    step();
    check("t2_irq1_acked", {31'b0, irq[1]}, 32'd0);

    // ch2 period 5, stopped after two ticks
    t = cycle;
    a = first_tick(t, tb_presc) + PRESCALE;
    cmd(2'd1, 2, 5, 1'b0);
    step();
    run_to(a + 1);
    check("t4_active2_run", {31'b0, active[2]}, 32'd1);
    cmd(2'd2, 2, 0, 1'b0);
    step();
    check("t4_active2_stop", {31'b0, active[2]}, 32'd0);
    repeat (40) step();
    check("t4_no_irq2", {31'b0, irq[2]}, 32'd0);

    // zero period and reserved op are ignored
    cmd(2'd1, 3, 0, 1'b1);
    step();
    check("t5_period0", {31'b0, active[3]}, 32'd0);
    cmd(2'd3, 3, 5, 1'b1);
    step();
    check("t5_reserved_op", {31'b0, active[3]}, 32'd0);
    check("t5_ch0_unaffected", {31'b0, active[0]}, 32'd1);
    check("t5_irq0_sticky", {31'b0, irq[0]}, 32'd1);

    // asynchronous reset mid-operation
    #2 reset = 1'b0;
    #1;
    check("t5_rst_active", {28'b0, active}, 32'd0);
    check("t5_rst_irq", {28'b0, irq}, 32'd0);
    check("t5_rst_ready", {31'b0, cmd_ready}, 32'd0);
    check("t5_rst_overrun", {28'b0, overrun}, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    check("t5_ready_back", {31'b0, cmd_ready}, 32'd1);

    // ch0 period 1 periodic, two expiries without ack
    t = cycle;
    a = first_tick(t, tb_presc);
    cmd(2'd1, 0, 1, 1'b1);
    sb.push_back('{a + 1, 0});
    run_to(a + 1);
    check("t6_ovr_first", {31'b0, overrun[0]}, 32'd0);
    run_to(a + 5);
    check("t6_ovr_set", {31'b0, overrun[0]}, {31'b0, OVR_EXP});
    check("t6_irq_held", {31'b0, irq[0]}, 32'd1);
    run_to(a + 6);
    irq_ack = 4'b0001;
    step();
    check("t6_ovr_clear", {31'b0, overrun[0]}, 32'd0);
    check("t6_irq_clear", {31'b0, irq[0]}, 32'd0);
    sb.push_back('{a + 9, 0});
    run_to(a + 9);
    cmd(2'd2, 0, 0, 1'b0);
    step();
    check("t6_stop0", {31'b0, active[0]}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
